adder_arbiter: RTL and testbench

- Shares one 8-bit ripple adder slice between two requesters.
- Each request is a multi-byte add with carry-in. The block runs it as BYTES sequential 8-bit passes, chaining the carry through a register.
- Round-robin arbitration, valid/ready on both request ports, result held until the consumer accepts it.
- Sits between the two client units and the shared adder datapath.

---
 rtl/adder_arbiter_pkg.sv | 16 +
 rtl/adder_arbiter_slice.sv | 16 +
 rtl/adder_arbiter.sv | 134 +++++++++++++
 tb/tb_adder_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_arbiter_pkg.sv
// adder_arbiter shared types and constants.
// Optional signed overflow output: define ADDER_ARBITER_OVF_EN.
package adder_arbiter_pkg;

  localparam int NUM_REQ = 2;
  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  typedef logic [$clog2(NUM_REQ)-1:0] req_id_t;

endpackage

// File: rtl/adder_arbiter_slice.sv
// adder_arbiter shared slice: one WIDTH-bit add with carry in/out.
// Purely combinational; sequencing lives in adder_arbiter.
module adder_slice #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b}
                   + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/adder_arbiter.sv
// Two-requester round-robin front end for one shared adder slice.
// Optional signed overflow output: define ADDER_ARBITER_OVF_EN.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int WIDTH = SLICE_W,
  parameter int BYTES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [WIDTH*BYTES-1:0] req0_a,
  input  logic [WIDTH*BYTES-1:0] req0_b,
  input  logic                   req0_cin,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [WIDTH*BYTES-1:0] req1_a,
  input  logic [WIDTH*BYTES-1:0] req1_b,
  input  logic                   req1_cin,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [WIDTH*BYTES-1:0] res_sum,
  output logic                   res_cout,
  output logic                   res_id,
  output logic                   res_ovf
);

  localparam int OPW = WIDTH * BYTES;
  localparam int CW  = (BYTES > 1) ? $clog2(BYTES) : 1;

  state_t         state, state_n;
  req_id_t        grant, last_grant, owner;
  logic [OPW-1:0] a_r, b_r, sum_r;
  logic           carry;
  logic [CW-1:0]  count;
  logic [WIDTH-1:0] sa, sb, ss;
  logic           sc;
  logic           take, last;

  always_comb begin
    grant = req_id_t'(0);
    unique case (1'b1)
      (req0_valid && req1_valid):  grant = ~last_grant;
      (req1_valid && !req0_valid): grant = req_id_t'(1);
      default:                     grant = req_id_t'(0);
    endcase
  end

  assign take = (state == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = (state == IDLE) && req0_valid
                    && (grant == req_id_t'(0));
  assign req1_ready = (state == IDLE) && req1_valid
                    && (grant == req_id_t'(1));

  assign sa   = a_r[int'(count)*WIDTH +: WIDTH];
  assign sb   = b_r[int'(count)*WIDTH +: WIDTH];
  assign last = (count == CW'(BYTES - 1));

  adder_slice #(.WIDTH(WIDTH)) u_slice (
    .a    (sa),
    .b    (sb),
    .cin  (carry),
    .s    (ss),
    .cout (sc)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (take) state_n = CALC;
      CALC:    if (last) state_n = DONE;
      DONE:    if (res_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r        <= '0;
      b_r        <= '0;
      sum_r      <= '0;
      carry      <= 1'b0;
      count      <= '0;
      owner      <= req_id_t'(0);
      last_grant <= req_id_t'(1);
    end else begin
      unique case (state)
        IDLE: if (take) begin
          a_r        <= grant[0] ? req1_a   : req0_a;
          b_r        <= grant[0] ? req1_b   : req0_b;
          carry      <= grant[0] ? req1_cin : req0_cin;
          count      <= '0;
          owner      <= grant;
          last_grant <= grant;
        end
        CALC: begin
          sum_r[int'(count)*WIDTH +: WIDTH] <= ss;
          carry <= sc;
          if (!last) count <= count + CW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef ADDER_ARBITER_OVF_EN
  logic ovf_r;

  // Overflow is judged on the top slice, i.e. the operand sign bits.
  always_ff @(posedge clk) begin
    if (rst)
      ovf_r <= 1'b0;
    else if (state == CALC && last)
      ovf_r <= (sa[WIDTH-1] == sb[WIDTH-1])
            && (ss[WIDTH-1] != sa[WIDTH-1]);
  end

  assign res_ovf = ovf_r;
`else
  assign res_ovf = 1'b0;
`endif

  assign res_valid = (state == DONE);
  assign res_sum   = sum_r;
  assign res_cout  = carry;
  assign res_id    = owner[0];

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter.
// Directed and random ops against an arithmetic reference model.
module tb_adder_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_cin;
  logic        req1_valid, req1_ready, req1_cin;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        res_valid, res_ready, res_cout, res_id, res_ovf;
  logic [15:0] res_sum;

  int tests = 0;
  int fails = 0;
  bit last_g;

  adder_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_sum    (res_sum),
    .res_cout   (res_cout),
    .res_id     (res_id),
    .res_ovf    (res_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] ref_add(
      input logic [15:0] a, input logic [15:0] b,
      input logic c);
    return {1'b0, a} + {1'b0, b} + {16'd0, c};
  endfunction

  function automatic logic ref_ovf(
      input logic [15:0] a, input logic [15:0] b,
      input logic c);
    logic [16:0] r;
`ifdef ADDER_ARBITER_OVF_EN
    r = ref_add(a, b, c);
    return (a[15] == b[15]) && (r[15] != a[15]);
`else
    r = 17'd0;
    return r[0];
`endif
  endfunction

  // Called at a negedge; returns right after the accepting edge.
  task automatic send(input int id,
                      input logic [15:0] a,
                      input logic [15:0] b,
                      input logic c);
    bit rdy;
    rdy = 1'b0;
    if (id == 0) begin
      req0_a = a; req0_b = b; req0_cin = c; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_cin = c; req1_valid = 1'b1;
    end
    for (int i = 0; i < 12; i++) begin
      #1;
      rdy = (id == 0) ? req0_ready : req1_ready;
      @(posedge clk);
      if (rdy) break;
      @(negedge clk);
    end
    chk("accept", {31'd0, rdy}, 32'd1);
    if (rdy) last_g = id[0];
  endtask

  task automatic wait_result(output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      n = i;
      if (res_valid) break;
    end
    chk("res_valid_seen", {31'd0, res_valid}, 32'd1);
  endtask

  task automatic check_res(input string tag, input int id,
                           input logic [15:0] a,
                           input logic [15:0] b,
                           input logic c);
    logic [16:0] r;
    r = ref_add(a, b, c);
    chk({tag, "_sum"}, {16'd0, res_sum}, {16'd0, r[15:0]});
    chk({tag, "_cout"}, {31'd0, res_cout}, {31'd0, r[16]});
    chk({tag, "_id"}, {31'd0, res_id}, id);
    chk({tag, "_ovf"}, {31'd0, res_ovf},
        {31'd0, ref_ovf(a, b, c)});
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    chk("res_valid_drop", {31'd0, res_valid}, 32'd0);
  endtask

  task automatic op(input string tag, input int id,
                    input logic [15:0] a,
                    input logic [15:0] b,
                    input logic c);
    int n;
    send(id, a, b, c);
    wait_result(n);
    chk({tag, "_latency"}, n, 32'd3);
    check_res(tag, id, a, b, c);
    consume();
  endtask

  initial begin
    int n;
    int exp_id;
    int id;
    logic [15:0] ra, rb;
    logic rc;
    int dly;

    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    res_ready = 1'b0;
    last_g = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_sum", {16'd0, res_sum}, 32'd0);
    chk("rst_cout", {31'd0, res_cout}, 32'd0);
    chk("rst_id", {31'd0, res_id}, 32'd0);
    chk("rst_ovf", {31'd0, res_ovf}, 32'd0);
    chk("rst_rdy", {30'd0, req1_ready, req0_ready}, 32'd0);

    // Tie right after reset, both requesters held valid.
    req0_a = 16'd1; req0_b = 16'd1; req0_cin = 1'b0;
    req1_a = 16'd2; req1_b = 16'd2; req1_cin = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    res_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_id = last_g ? 0 : 1;
      last_g = exp_id[0];
      n = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (res_valid) break;
      end
      chk("rr_valid", {31'd0, res_valid}, 32'd1);
      chk("rr_id", {31'd0, res_id}, exp_id);
      chk("rr_sum", {16'd0, res_sum}, exp_id == 0 ? 32'd2 : 32'd4);
      if (k == 2) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;

    op("basic", 0, 16'h00FF, 16'h0001, 1'b0);
    op("carry", 1, 16'hFFFF, 16'h0000, 1'b1);

    // Backpressure with a competing requester waiting.
    send(0, 16'h1234, 16'h1111, 1'b0);
    wait_result(n);
    req1_a = 16'h5555; req1_b = 16'h1; req1_cin = 1'b0;
    req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, res_valid}, 32'd1);
      chk("bp_sum", {16'd0, res_sum}, 32'h2345);
      chk("bp_rdy", {30'd0, req1_ready, req0_ready}, 32'd0);
    end
    req1_valid = 1'b0;
    consume();

    // Reset during the second pass.
    send(1, 16'hABCD, 16'h1111, 1'b1);
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    last_g = 1'b1;
    chk("mrst_valid", {31'd0, res_valid}, 32'd0);
    chk("mrst_sum", {16'd0, res_sum}, 32'd0);
    chk("mrst_cout", {31'd0, res_cout}, 32'd0);
    chk("mrst_id", {31'd0, res_id}, 32'd0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (res_valid) n++;
    end
    chk("mrst_no_result", n, 32'd0);
    op("post_rst", 1, 16'h0F0F, 16'hF0F0, 1'b1);

`ifdef ADDER_ARBITER_OVF_EN
    op("ovf_pos", 0, 16'h7FFF, 16'h0001, 1'b0);
    op("ovf_neg", 1, 16'h8000, 16'h8000, 1'b0);
`endif

    for (int k = 0; k < 10; k++) begin
      id = int'($urandom_range(0, 1));
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      dly = int'($urandom_range(0, 3));
      send(id, ra, rb, rc);
      wait_result(n);
      chk("rnd_latency", n, 32'd3);
      for (int i = 0; i < dly; i++) @(negedge clk);
      check_res("rnd", id, ra, rb, rc);
      consume();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
